// File: rtl/mem_port_ctrl.sv
// Single-port memory access controller: one request at a time, read/write strobes, optional access timeout.
// Optional feature: define MEM_TIMEOUT_EN to enable the MAX_WAIT wait-cycle timeout.
module mem_port_ctrl #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] num_access
);

  if (MAX_WAIT == 0 || MAX_WAIT > 255) begin : g_max_wait_range
    $error("mem_port_ctrl: MAX_WAIT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] addr_d, wdata_d, rdata_d, num_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = 8;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_d;
`endif

  // Only the write strobe cycle drives the shared bus; writeM is high exactly in WRITE.
  assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

  // Next-state and next-value logic
  always_comb begin
    state_d = state_q;
    addr_d  = address;
    wdata_d = wdata_q;
    rdata_d = rsp_rdata;
    num_d   = num_access;
`ifdef MEM_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_write ? WRITE : READ;
`ifdef MEM_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      READ, WRITE: begin
        if (inputReady) begin
          state_d = RESP;
          num_d   = num_access + WORD_SIZE'(1);
          if (state_q == READ) rdata_d = data;
        end
`ifdef MEM_TIMEOUT_EN
        // Completion on the same edge as the last wait cycle takes priority.
        else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      address    <= '0;
      wdata_q    <= '0;
      rsp_rdata  <= '0;
      num_access <= '0;
      rsp_valid  <= 1'b0;
      req_ready  <= 1'b1;
      readM      <= 1'b0;
      writeM     <= 1'b0;
    end else begin
      state_q    <= state_d;
      address    <= addr_d;
      wdata_q    <= wdata_d;
      rsp_rdata  <= rdata_d;
      num_access <= num_d;
      rsp_valid  <= (state_d == RESP);
      req_ready  <= (state_d == IDLE);
      readM      <= (state_d == READ);
      writeM     <= (state_d == WRITE);
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Wait counter and error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q  <= '0;
      rsp_err <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      rsp_err <= err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: random accesses against a memory model, reset abort, counter wrap.
// Timeout scenarios run only when MEM_TIMEOUT_EN is defined.
module tb_mem_port_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned MW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [W-1:0] req_addr = '0, req_wdata = '0;
  logic         req_ready, rsp_valid, rsp_err, readM, writeM;
  logic [W-1:0] rsp_rdata, address, num_access;
  wire  [W-1:0] data;
  logic         inputReady = 1'b0;
  logic         probe_en = 1'b0;

  logic [W-1:0] ram     [256];
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] model_num = '0;
  logic [W-1:0] model_rdata = '0;

  // Memory device: drives read data; a zero probe detects a DUT still driving the bus.
  assign data = readM ? ram[address[7:0]] : (probe_en ? {W{1'b0}} : {W{1'bz}});

  mem_port_ctrl #(.WORD_SIZE(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .num_access(num_access)
  );

  // Narrow instance so the completion counter wrap is reachable quickly.
  logic       req_valid_s = 1'b0;
  logic       req_write_s = 1'b0;
  logic [3:0] req_addr_s = 4'h3, req_wdata_s = 4'h0;
  logic       req_ready_s, rsp_valid_s, rsp_err_s, readM_s, writeM_s;
  logic [3:0] rsp_rdata_s, address_s, num_access_s;
  wire  [3:0] data_s;
  logic       inputReady_s = 1'b1;
  assign data_s = readM_s ? ~address_s : 4'bzzzz;

  mem_port_ctrl #(.WORD_SIZE(4), .MAX_WAIT(MW)) dut_s (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_s), .req_write(req_write_s),
    .req_addr(req_addr_s), .req_wdata(req_wdata_s), .req_ready(req_ready_s),
    .rsp_valid(rsp_valid_s), .rsp_rdata(rsp_rdata_s), .rsp_err(rsp_err_s),
    .readM(readM_s), .writeM(writeM_s), .address(address_s), .data(data_s),
    .inputReady(inputReady_s), .num_access(num_access_s)
  );

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
    logic [W-1:0] num;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory responder: acknowledges after ack_delay wait cycles of an active strobe.
  int ack_delay = 0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (readM || writeM) begin
      inputReady = (wcnt >= ack_delay);
      wcnt++;
    end else begin
      inputReady = 1'b0;
      wcnt = 0;
    end
  end

  always @(posedge clk) if (writeM && inputReady) ram[address[7:0]] <= data;

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("num_access", 32'(num_access), 32'(e.num));
      end
    end
  end

  function automatic void model_access(input logic w, input logic [W-1:0] a,
                                       input logic [W-1:0] wd, input bit to);
    if (to) model_rdata = '0;
    else begin
      model_num++;
      if (w) ref_mem[a[7:0]] = wd;
      else   model_rdata = ref_mem[a[7:0]];
    end
    exp_q.push_back('{model_rdata, to, model_num});
  endfunction

  task automatic run_txn(input logic w, input logic [W-1:0] a, input logic [W-1:0] wd,
                         input int dly, input bit hold);
    bit to;
    int exp_lat, edges;
    bit got;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    ack_delay = dly;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    to = 1'b0;
`ifdef MEM_TIMEOUT_EN
    to = (dly >= int'(MW));
`endif
    exp_lat = to ? int'(MW) : dly + 1;
    model_access(w, a, wd, to);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    edges = 0;
    got = 1'b0;
    while (!got && edges < 64) begin
      check("busy_ready", 32'(req_ready), 32'd0);
      check("readM", 32'(readM), 32'(!w));
      check("writeM", 32'(writeM), 32'(w));
      check("address", 32'(address), 32'(a));
      if (w) check("wdata_bus", 32'(data), 32'(wd));
      @(posedge clk); #1;
      edges++;
      got = rsp_valid;
    end
    check("rsp_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(edges), 32'(exp_lat));
      check("resp_ready", 32'(req_ready), 32'd0);
      check("resp_strobes", 32'({readM, writeM}), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ready_after", 32'(req_ready), 32'd1);
    check("idle_strobes", 32'({readM, writeM}), 32'd0);
    probe_en = 1'b1; #1;
    check("bus_released", 32'(data), 32'd0);
    probe_en = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      ram[i] = W'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16] = 16'h1234;
    ref_mem[16] = 16'h1234;

    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_num", 32'(num_access), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_strobes", 32'({readM, writeM}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    run_txn(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    run_txn(1'b1, 16'h0020, 16'hBEEF, 3, 1'b0);
    check("rdata_kept_after_write", 32'(rsp_rdata), 32'h1234);
    run_txn(1'b0, 16'h0020, 16'h0000, 1, 1'b1);
    run_txn(1'b1, 16'h0030, 16'h5A5A, 2, 1'b1);

    // Reset in the middle of a read aborts it without a response.
    @(negedge clk);
    ack_delay = 50;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0005;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_readM_active", 32'(readM), 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("abort_readM", 32'(readM), 32'd0);
    check("abort_num", 32'(num_access), 32'd0);
    check("abort_rdata", 32'(rsp_rdata), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    model_num = '0;
    model_rdata = '0;
    @(posedge clk); #1;
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ack_delay = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    model_access(1'b0, 16'h0010, 16'h0000, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("accept_after_reset", 32'(readM), 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 8);
    check("post_reset_rsp", 32'(rsp_valid), 32'd1);
    @(posedge clk);

    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom_range(0, 1)), W'($urandom_range(0, 31)), W'($urandom),
              int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

`ifdef MEM_TIMEOUT_EN
    run_txn(1'b0, 16'h0010, 16'h0000, 1000, 1'b0);
    run_txn(1'b0, 16'h0010, 16'h0000, 3, 1'b0);
    run_txn(1'b1, 16'h0040, 16'h7777, 1000, 1'b0);
    run_txn(1'b0, 16'h0040, 16'h0000, 0, 1'b0);
`endif

    // Counter wrap on the narrow instance: 16 reads bring it back to zero.
    @(negedge clk);
    req_valid_s = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!rsp_valid_s && n < 10);
      if (k == 16) req_valid_s = 1'b0;
      check("wrap_rsp_seen", 32'(rsp_valid_s), 32'd1);
      check("wrap_num", 32'(num_access_s), 32'(k % 16));
      check("wrap_rdata", 32'(rsp_rdata_s), 32'hC);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
